// File: rtl/ucsbece154a_rf_pkg.sv
// Shared types for the dual-write register file.
// State encoding and sticky error-bit positions.
package ucsbece154a_rf_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } rf_state_e;

    localparam int ERR_ZERO  = 0;
    localparam int ERR_WRITE = 1;

endpackage

// File: rtl/ucsbece154a_rf_clr_seq.sv
// Clear sequencer: sweeps every entry to zero after reset or clr_i,
// then holds ready until the next clear request.
module ucsbece154a_rf_clr_seq
    import ucsbece154a_rf_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn_i,
    input  logic          clr_i,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          ready
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    rf_state_e     state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        ready   = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end
            end
            ST_READY: begin
                ready = 1'b1;
                if (clr_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    assign clr_addr = cnt_q;

endmodule

// File: rtl/ucsbece154a_rf_mp.sv
// Dual-write register file, port A priority, hardware clear, sticky errors.
// Define UCSBECE154A_RF_BYPASS_EN to forward same-cycle writes to reads.
module ucsbece154a_rf_mp
    import ucsbece154a_rf_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rstn_i,
    input  logic [AW-1:0]    a1_i,
    input  logic [AW-1:0]    a2_i,
    output logic [WIDTH-1:0] rd1_o,
    output logic [WIDTH-1:0] rd2_o,
    input  logic             we3_i,
    input  logic [AW-1:0]    a3_i,
    input  logic [WIDTH-1:0] wd3_i,
    input  logic             we4_i,
    input  logic [AW-1:0]    a4_i,
    input  logic [WIDTH-1:0] wd4_i,
    input  logic             clr_i,
    output logic             ready_o,
    output logic [1:0]       err_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [1:0]       err_q, err_d;
    logic             clr_we;
    logic [AW-1:0]    clr_addr;
    logic             ready;
    logic             a_zero, b_zero, collide;
    logic             wa_en, wb_en;
    logic [AW-1:0]    ra [2];
    logic [WIDTH-1:0] rd [2];

    ucsbece154a_rf_clr_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_seq (
        .clk      (clk),
        .rstn_i   (rstn_i),
        .clr_i    (clr_i),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    always_comb begin
        a_zero  = (ZERO_REG != 0) && (a3_i == '0);
        b_zero  = (ZERO_REG != 0) && (a4_i == '0);
        collide = ready && we3_i && we4_i && (a3_i == a4_i);
        wa_en   = ready && we3_i && !a_zero;
        wb_en   = ready && we4_i && !b_zero && !collide;
        err_d   = err_q;
        if (ready) begin
            if ((we3_i && a_zero) || (we4_i && b_zero))
                err_d[ERR_ZERO] = 1'b1;
            if (collide)
                err_d[ERR_WRITE] = 1'b1;
        end else if (we3_i || we4_i) begin
            err_d[ERR_WRITE] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) err_q <= '0;
        else         err_q <= err_d;
    end

    // Port A written last so it wins on any overlap.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else begin
            if (wb_en) mem_q[a4_i] <= wd4_i;
            if (wa_en) mem_q[a3_i] <= wd3_i;
        end
    end

    assign ra[0] = a1_i;
    assign ra[1] = a2_i;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd[p] = mem_q[ra[p]];
            if (!ready)
                rd[p] = '0;
            else if ((ZERO_REG != 0) && (ra[p] == '0))
                rd[p] = '0;
`ifdef UCSBECE154A_RF_BYPASS_EN
            else if (wa_en && (a3_i == ra[p]))
                rd[p] = wd3_i;
            else if (wb_en && (a4_i == ra[p]))
                rd[p] = wd4_i;
`else
            else
                rd[p] = mem_q[ra[p]];
`endif
        end
    end

    assign rd1_o   = rd[0];
    assign rd2_o   = rd[1];
    assign ready_o = ready;
    assign err_o   = err_q;

endmodule

// File: tb/tb_ucsbece154a_rf_mp.sv
// Bench for ucsbece154a_rf_mp: a 32x32 ZERO_REG=1 file and a 8x16 ZERO_REG=0
// file share one stimulus stream and are checked against an array model.
module tb_ucsbece154a_rf_mp;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  a1, a2, a3, a4;
    logic [31:0] wd3, wd4;
    logic        we3, we4, clr;
    logic [31:0] rd1_0, rd2_0;
    logic [15:0] rd1_1, rd2_1;
    logic        rdy0, rdy1;
    logic [1:0]  err0, err1;

    int total = 0;
    int bad   = 0;

    logic [31:0] m [2][32];
    int          busy [2];
    logic [1:0]  e [2];
    int          dep [2] = '{32, 8};
    bit          zr  [2] = '{1'b1, 1'b0};
    logic [31:0] msk [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};

    always #5 clk = ~clk;

    ucsbece154a_rf_mp #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) u0 (
        .clk(clk), .rstn_i(rstn),
        .a1_i(a1), .a2_i(a2), .rd1_o(rd1_0), .rd2_o(rd2_0),
        .we3_i(we3), .a3_i(a3), .wd3_i(wd3),
        .we4_i(we4), .a4_i(a4), .wd4_i(wd4),
        .clr_i(clr), .ready_o(rdy0), .err_o(err0)
    );

    ucsbece154a_rf_mp #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) u1 (
        .clk(clk), .rstn_i(rstn),
        .a1_i(a1[2:0]), .a2_i(a2[2:0]), .rd1_o(rd1_1), .rd2_o(rd2_1),
        .we3_i(we3), .a3_i(a3[2:0]), .wd3_i(wd3[15:0]),
        .we4_i(we4), .a4_i(a4[2:0]), .wd4_i(wd4[15:0]),
        .clr_i(clr), .ready_o(rdy1), .err_o(err1)
    );

    function automatic logic [31:0] exp_rd(int i, logic [4:0] a);
        int ai;
        int a3i;
        int a4i;
        bit col;
        ai  = int'(a) % dep[i];
        a3i = int'(a3) % dep[i];
        a4i = int'(a4) % dep[i];
        col = we3 && we4 && (a3i == a4i);
        if (busy[i] != 0) return 32'h0;
        if (zr[i] && ai == 0) return 32'h0;
`ifdef UCSBECE154A_RF_BYPASS_EN
        if (we3 && a3i == ai && !(zr[i] && a3i == 0)) return wd3 & msk[i];
        if (we4 && a4i == ai && !(zr[i] && a4i == 0) && !col)
            return wd4 & msk[i];
`else
        if (col) ai = ai;
`endif
        return m[i][ai];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check(input string tag);
        chk({tag, "/rd1_32"}, rd1_0, exp_rd(0, a1));
        chk({tag, "/rd2_32"}, rd2_0, exp_rd(0, a2));
        chk({tag, "/rdy_32"}, {31'b0, rdy0}, {31'b0, busy[0] == 0});
        chk({tag, "/err_32"}, {30'b0, err0}, {30'b0, e[0]});
        chk({tag, "/rd1_8"}, {16'b0, rd1_1}, exp_rd(1, a1));
        chk({tag, "/rd2_8"}, {16'b0, rd2_1}, exp_rd(1, a2));
        chk({tag, "/rdy_8"}, {31'b0, rdy1}, {31'b0, busy[1] == 0});
        chk({tag, "/err_8"}, {30'b0, err1}, {30'b0, e[1]});
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int  a3i;
            int  a4i;
            bit  az;
            bit  bz;
            bit  col;
            if (!rstn) continue;
            if (busy[i] != 0) begin
                if (we3 || we4) e[i][1] = 1'b1;
                m[i][dep[i] - busy[i]] = 32'h0;
                busy[i]--;
            end else begin
                a3i = int'(a3) % dep[i];
                a4i = int'(a4) % dep[i];
                az  = zr[i] && a3i == 0;
                bz  = zr[i] && a4i == 0;
                col = we3 && we4 && (a3i == a4i);
                if ((we3 && az) || (we4 && bz)) e[i][0] = 1'b1;
                if (col) e[i][1] = 1'b1;
                if (we4 && !bz && !col) m[i][a4i] = wd4 & msk[i];
                if (we3 && !az) m[i][a3i] = wd3 & msk[i];
                if (clr) busy[i] = dep[i];
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag);
        #1;
        check(tag);
        tick();
    endtask

    task automatic idle();
        we3 = 1'b0;
        we4 = 1'b0;
        clr = 1'b0;
        a1  = 5'($urandom);
        a2  = 5'($urandom);
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            busy[i] = dep[i];
            e[i]    = 2'b00;
        end
        #1;
        check("reset");
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        a3 = '0; a4 = '0; wd3 = '0; wd4 = '0;
        idle();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 32; j++) m[i][j] = 32'h0;
        @(posedge clk);
        #1;

        do_reset();
        for (int c = 0; c < 36; c++) begin
            idle();
            step("clear_sweep");
        end
        for (int i = 0; i < 32; i++) begin
            idle();
            a1 = 5'(i);
            a2 = 5'(31 - i);
            step("read_zero");
        end

        idle();
        we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEAD_BEEF; a1 = 5'd5;
        step("wr5");
        idle();
        a1 = 5'd5;
        step("rd5");

        idle();
        we3 = 1'b1; a3 = 5'd7; wd3 = 32'h11;
        we4 = 1'b1; a4 = 5'd7; wd4 = 32'h22;
        a1 = 5'd7;
        step("coll");
        idle();
        we3 = 1'b1; a3 = 5'd7; wd3 = 32'h11;
        we4 = 1'b1; a4 = 5'd8; wd4 = 32'h22;
        a1 = 5'd7; a2 = 5'd8;
        step("nocoll");
        idle();
        a1 = 5'd7; a2 = 5'd8;
        step("rd78");

        idle();
        we3 = 1'b1; a3 = 5'd0; wd3 = 32'h0000_FFFF; a1 = 5'd0;
        step("zero_wr");
        idle();
        a1 = 5'd0;
        step("zero_rd");

        do_reset();
        for (int c = 0; c < 34; c++) begin
            idle();
            step("clear2");
        end
        for (int i = 0; i < 16; i++) begin
            idle();
            we3 = 1'b1; a3 = 5'(i);      wd3 = 32'hA5A5_A5A5;
            we4 = 1'b1; a4 = 5'(i + 16); wd4 = 32'hA5A5_A5A5;
            step("fill");
        end
        for (int i = 0; i < 32; i++) begin
            idle();
            a1 = 5'(i);
            a2 = 5'(31 - i);
            step("read_fill");
        end
        idle();
        clr = 1'b1;
        step("clr_pulse");
        idle();
        we3 = 1'b1; a3 = 5'd3; wd3 = 32'h1234_5678;
        step("wr_in_clear");
        for (int c = 0; c < 34; c++) begin
            idle();
            step("clear3");
        end
        for (int i = 0; i < 32; i++) begin
            idle();
            a1 = 5'(i);
            a2 = 5'(31 - i);
            step("read_cleared");
        end

        do_reset();
        for (int c = 0; c < 10; c++) begin
            idle();
            step("pre_midrst");
        end
        do_reset();
        for (int c = 0; c < 36; c++) begin
            idle();
            step("post_midrst");
        end

        for (int c = 0; c < 400; c++) begin
            idle();
            we3 = 1'($urandom);
            we4 = 1'($urandom);
            a3  = 5'($urandom);
            a4  = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom);
            wd3 = $urandom;
            wd4 = $urandom;
            a1  = ($urandom_range(0, 1) == 0) ? a3 : 5'($urandom);
            a2  = ($urandom_range(0, 1) == 0) ? a4 : 5'($urandom);
            clr = ($urandom_range(0, 79) == 0);
            step("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
